// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO registers.
// Multiplies wait MUL_CYCLES cycles; divides use a 32-step radix-2 restoring loop.
module muldiv_hilo_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sgn;
  logic [XLEN-1:0]   r_opa;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_raw_a;
  logic [XLEN-1:0]   r_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;

  logic              w_idle;
  logic              w_accept;
  logic              w_mt;
  logic              w_sgn;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [63:0]       w_prod;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_sub;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;

  // Issue decode: only MULT/MULTU/DIV/DIVU start the sequencer.
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = op_valid && !op[2] && w_idle && !flush;
  assign w_mt     = op_valid && w_idle && !flush && ((op == OP_MTHI) || (op == OP_MTLO));
  assign w_sgn    = !op[0];

  assign stall = w_accept || (((r_state == S_MUL) || (r_state == S_DIV)) && !flush);

  assign w_abs_a = (w_sgn && src_a[XLEN-1]) ? (~src_a + 32'd1) : src_a;
  assign w_abs_b = (w_sgn && src_b[XLEN-1]) ? (~src_b + 32'd1) : src_b;

  // Only the low 64 bits of the sign/zero-extended product are architectural.
  assign w_prod = 64'($signed({r_sgn & r_opa[XLEN-1], r_opa})) *
                  64'($signed({r_sgn & r_opb[XLEN-1], r_opb}));

  // One restoring-division step; r_opa shifts the dividend out and quotient bits in.
  assign w_shift  = {r_rem, r_opa[XLEN-1]};
  assign w_sub    = w_shift - {1'b0, r_opb};
  assign w_qbit   = !w_sub[XLEN];
  assign w_rem_nx = w_qbit ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nx = {r_opa[XLEN-2:0], w_qbit};
  assign w_q_fix  = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_r_fix  = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_raw_a <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_cnt   <= '0;
              r_sgn   <= w_sgn;
              r_raw_a <= src_a;
              r_rem   <= '0;
              r_dz    <= (src_b == '0);
              r_neg_q <= w_sgn && (src_a[XLEN-1] ^ src_b[XLEN-1]);
              r_neg_r <= w_sgn && src_a[XLEN-1];
              busy    <= 1'b1;
              if (op[1]) begin
                r_opa   <= w_abs_a;
                r_opb   <= w_abs_b;
                r_state <= S_DIV;
              end else begin
                r_opa   <= src_a;
                r_opb   <= src_b;
                r_state <= S_MUL;
              end
            end else if (w_mt) begin
              if (op == OP_MTHI) hi <= src_a;
              else               lo <= src_a;
            end
          end
          S_MUL: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == MUL_LAST) begin
              hi      <= w_prod[63:32];
              lo      <= w_prod[31:0];
              r_state <= S_FINISH;
              done    <= 1'b1;
            end
          end
          S_DIV: begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_opa <= w_quo_nx;
            r_rem <= w_rem_nx;
            if (r_cnt == DIV_LAST) begin
              // Divide by zero bypasses sign fixup and returns the raw dividend.
              if (r_dz) begin
                hi <= r_raw_a;
                lo <= '1;
              end else begin
                hi <= w_r_fix;
                lo <= w_q_fix;
              end
              r_state <= S_FINISH;
              done    <= 1'b1;
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;

  localparam int unsigned MC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Architectural result {HI,LO} straight from the instruction definitions.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        return 64'(p);
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [63:0] r;
    r = ref_md(o, a, b);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check("md_t0_busy", 64'(busy), 64'd0);
    n = 0;
    while (stall && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    check("md_stall_cycles", 64'(n), o[1] ? 64'd33 : 64'(MC + 1));
    check("md_done", 64'(done), 64'd1);
    check("md_busy_fin", 64'(busy), 64'd1);
    m_hi = r[63:32];
    m_lo = r[31:0];
    check("md_hi", 64'(hi), 64'(m_hi));
    check("md_lo", 64'(lo), 64'(m_lo));
    op_valid = 1'b0;
    @(posedge clk); #1;
    check("md_done_drop", 64'(done), 64'd0);
    check("md_idle", 64'(busy), 64'd0);
  endtask

  task automatic issue_mt(input logic [2:0] o, input logic [31:0] a);
    op_valid = 1'b1; op = o; src_a = a; src_b = $urandom;
    #1;
    check("mt_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (o == 3'd4) m_hi = a;
    if (o == 3'd5) m_lo = a;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
  endtask

  initial begin
    int          dones;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn = 1'b0; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    issue_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    issue_md(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue_md(3'd3, 32'd100, 32'd7);
    issue_md(3'd2, 32'd5, 32'd0);
    issue_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue_md(3'd3, 32'h8000_0001, 32'd0);

    // Flush mid-divide discards the result.
    issue_mt(3'd4, 32'hAAAA_AAAA);
    issue_mt(3'd5, 32'hAAAA_AAAA);
    op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    #1;
    repeat (10) begin @(posedge clk); #1; end
    check("fl_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    #1;
    check("fl_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    dones = 0;
    repeat (40) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("fl_no_done", 64'(dones), 64'd0);
    check("fl_hi", 64'(hi), 64'hAAAA_AAAA);
    check("fl_lo", 64'(lo), 64'hAAAA_AAAA);
    issue_md(3'd1, 32'd3, 32'd4);

    // MULT then MTHI right after FINISH.
    issue_md(3'd0, 32'd2, 32'd3);
    issue_mt(3'd4, 32'h55);
    check("mfhi", 64'(hi), 64'h55);
    check("mflo", 64'(lo), 64'd6);

    // MTHI coincident with flush must not write.
    op_valid = 1'b1; op = 3'd4; src_a = 32'h99; flush = 1'b1;
    #1;
    check("mtfl_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    check("mtfl_hi", 64'(hi), 64'(m_hi));

    // Ignored opcodes.
    issue_mt(3'd6, 32'h1111_2222);
    issue_mt(3'd7, 32'h3333_4444);

    // Reset in the middle of a divide.
    op_valid = 1'b1; op = 3'd2; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    #1;
    repeat (10) begin @(posedge clk); #1; end
    resetn = 1'b0; op_valid = 1'b0;
    #1;
    check("rmid_hi", 64'(hi), 64'd0);
    check("rmid_lo", 64'(lo), 64'd0);
    check("rmid_stall", 64'(stall), 64'd0);
    check("rmid_busy", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    issue_mt(3'd5, 32'h1234);

    // Random mix against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'(-int'($urandom_range(1, 9)));
        default: ;
      endcase
      if (ro[2]) issue_mt(ro, ra);
      else       issue_md(ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
